// File: rtl/qlm_pipe_mult.sv
// qlm_pipe_mult: 3-stage Mitchell log-domain signed multiplier, valid/ready.
// Define QLM_TC_EN for exact two's-complement signs (default: ones-complement).
module qlm_pipe_mult #(
    parameter int WIDTH = 8,
    parameter int QBITS = 3,
    parameter int TAG_W = 4
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   x_i,
    input  logic [WIDTH-1:0]   y_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] p_o,
    output logic [TAG_W-1:0]   tag_o
);
    localparam int KW = $clog2(WIDTH);
    localparam int LW = KW + QBITS;
    localparam int SW = LW + 1;
    localparam int PW = 2 * WIDTH;
    localparam int XW = PW + QBITS;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
`ifdef QLM_TC_EN
        return v[WIDTH-1] ? -v : v;
`else
        return v ^ {WIDTH{v[WIDTH-1]}};
`endif
    endfunction

    // Normalise so the leading one sits at the MSB; the bits under it are f.
    function automatic logic [LW-1:0] log_enc(input logic [WIDTH-1:0] a);
        logic [KW-1:0]    k;
        logic [WIDTH-1:0] norm;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) k = KW'(i);
        end
        norm = a << (WIDTH - 1 - int'(k));
        return {k, QBITS'(norm >> (WIDTH - 1 - QBITS))};
    endfunction

    logic             v1_q, v2_q, v3_q;
    logic             rdy1, rdy2, rdy3;

    logic [WIDTH-1:0] ax, ay;
    logic [LW-1:0]    lx_d, ly_d, lx_q, ly_q;
    logic             sgn1_d, zero1_d, sgn1_q, zero1_q;
    logic [TAG_W-1:0] tag1_q;

    logic [SW-1:0]    sum_d, sum_q;
    logic             sgn2_q, zero2_q;
    logic [TAG_W-1:0] tag2_q;

    logic [QBITS:0]   m;
    logic [KW:0]      c;
    logic [XW-1:0]    wide;
    logic [PW-1:0]    mag;
    logic [PW-1:0]    p_d, p_q;
    logic [TAG_W-1:0] tag3_q;

    assign rdy3       = out_ready_i | ~v3_q;
    assign rdy2       = rdy3 | ~v2_q;
    assign rdy1       = rdy2 | ~v1_q;
    assign in_ready_o = rdy1;

    always_comb begin
        ax      = magnitude(x_i);
        ay      = magnitude(y_i);
        lx_d    = log_enc(ax);
        ly_d    = log_enc(ay);
        sgn1_d  = x_i[WIDTH-1] ^ y_i[WIDTH-1];
        zero1_d = (ax == '0) | (ay == '0);
    end

    assign sum_d = SW'(lx_q) + SW'(ly_q);

    always_comb begin
        m    = {1'b1, sum_q[QBITS-1:0]};
        c    = sum_q[SW-1:QBITS];
        wide = XW'(m) << c;
        mag  = PW'(wide >> QBITS);
`ifdef QLM_TC_EN
        p_d  = zero2_q ? '0 : (sgn2_q ? -mag : mag);
`else
        p_d  = zero2_q ? '0 : (mag ^ {PW{sgn2_q}});
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            lx_q    <= '0;
            ly_q    <= '0;
            sgn1_q  <= 1'b0;
            zero1_q <= 1'b0;
            tag1_q  <= '0;
            sum_q   <= '0;
            sgn2_q  <= 1'b0;
            zero2_q <= 1'b0;
            tag2_q  <= '0;
            p_q     <= '0;
            tag3_q  <= '0;
        end else begin
            if (rdy1) v1_q <= in_valid_i;
            if (rdy1 && in_valid_i) begin
                lx_q    <= lx_d;
                ly_q    <= ly_d;
                sgn1_q  <= sgn1_d;
                zero1_q <= zero1_d;
                tag1_q  <= tag_i;
            end
            if (rdy2) v2_q <= v1_q;
            if (rdy2 && v1_q) begin
                sum_q   <= sum_d;
                sgn2_q  <= sgn1_q;
                zero2_q <= zero1_q;
                tag2_q  <= tag1_q;
            end
            if (rdy3) v3_q <= v2_q;
            if (rdy3 && v2_q) begin
                p_q    <= p_d;
                tag3_q <= tag2_q;
            end
        end
    end

    assign out_valid_o = v3_q;
    assign p_o         = p_q;
    assign tag_o       = tag3_q;

endmodule
